// File: rtl/rx_axis_adapter.sv
// rx_axis_adapter: converts the RX datapath {payload, mty} beat stream into an
// AXI4-Stream master with full tready backpressure.
//
// Storage is a two-entry skid buffer:
//   O : output register, drives m_axis_* directly
//   S : skid register, catches a beat accepted while O is held
// rx_int_ready is simply !S.valid, so there is no combinational path from
// m_axis_tready back to rx_int_ready.
//
// mty handling:
//   0        idle, beat ignored (not stored, no overflow, not counted)
//   BYTES    full, non-last beat
//   1..B-1   last beat with mty valid bytes
//   >BYTES   treated as BYTES-1
// tkeep and tlast are computed once, on entry, and stored alongside the payload.
//
// Optional build macro: RX_STATS_EN adds the frame_cnt and beat_cnt ports and counters.
// Without it, neither the counters nor their ports exist.
module rx_axis_adapter #(
   parameter int DWIDTH = 112,
   parameter int MTY_W  = 4,
   parameter int CNT_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DWIDTH+MTY_W-1:0]   rx_int_data,
   input  logic                      rx_int_valid,
   output logic                      rx_int_ready,
   output logic [DWIDTH-1:0]         m_axis_tdata,
   output logic [DWIDTH/8-1:0]       m_axis_tkeep,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      overflow
`ifdef RX_STATS_EN
   ,
   output logic [CNT_W-1:0]          frame_cnt,
   output logic [CNT_W-1:0]          beat_cnt
`endif
);

   localparam int BYTES = DWIDTH / 8;
   localparam logic [MTY_W-1:0] MTY_FULL = MTY_W'(BYTES);
   localparam logic [MTY_W-1:0] MTY_MAXL = MTY_W'(BYTES - 1);

   logic [DWIDTH-1:0] in_data;
   logic [MTY_W-1:0]  in_mty;
   logic [MTY_W-1:0]  in_mty_eff;
   logic [BYTES-1:0]  in_keep;
   logic              in_last;
   logic              in_nonidle;
   logic              accept;
   logic              pop;

   logic [DWIDTH-1:0] o_data_q, o_data_d;
   logic [BYTES-1:0]  o_keep_q, o_keep_d;
   logic              o_last_q, o_last_d;
   logic              o_valid_q, o_valid_d;

   logic [DWIDTH-1:0] s_data_q, s_data_d;
   logic [BYTES-1:0]  s_keep_q, s_keep_d;
   logic              s_last_q, s_last_d;
   logic              s_valid_q, s_valid_d;

   logic              overflow_q, overflow_d;

   assign in_data    = rx_int_data[DWIDTH+MTY_W-1:MTY_W];
   assign in_mty     = rx_int_data[MTY_W-1:0];
   assign in_nonidle = (in_mty != '0);

   assign rx_int_ready = ~s_valid_q;
   assign accept       = rx_int_valid & rx_int_ready & in_nonidle;
   assign pop          = o_valid_q & m_axis_tready;

   // Decode the incoming mty into stored byte enables and end-of-frame flag.
   always_comb begin
      in_mty_eff = (in_mty > MTY_FULL) ? MTY_MAXL : in_mty;
      in_last    = (in_mty_eff != MTY_FULL);
      in_keep    = '0;
      for (int i = 0; i < BYTES; i++) begin
         in_keep[BYTES-1-i] = (int'(in_mty_eff) > i);
      end
   end

   // Skid-buffer next state: refill O from S first, then from the input;
   // a beat arriving while O is held parks in S.
   always_comb begin
      o_data_d  = o_data_q;
      o_keep_d  = o_keep_q;
      o_last_d  = o_last_q;
      o_valid_d = o_valid_q;
      s_data_d  = s_data_q;
      s_keep_d  = s_keep_q;
      s_last_d  = s_last_q;
      s_valid_d = s_valid_q;

      if (!o_valid_q || pop) begin
         if (s_valid_q) begin
            o_data_d  = s_data_q;
            o_keep_d  = s_keep_q;
            o_last_d  = s_last_q;
            o_valid_d = 1'b1;
            if (accept) begin
               s_data_d  = in_data;
               s_keep_d  = in_keep;
               s_last_d  = in_last;
               s_valid_d = 1'b1;
            end else begin
               s_valid_d = 1'b0;
            end
         end else if (accept) begin
            o_data_d  = in_data;
            o_keep_d  = in_keep;
            o_last_d  = in_last;
            o_valid_d = 1'b1;
         end else begin
            o_valid_d = 1'b0;
         end
      end else if (accept) begin
         s_data_d  = in_data;
         s_keep_d  = in_keep;
         s_last_d  = in_last;
         s_valid_d = 1'b1;
      end
   end

   // Sticky flag for a non-idle beat offered while the buffer is full.
   always_comb begin
      overflow_d = overflow_q | (rx_int_valid & in_nonidle & ~rx_int_ready);
   end

   // Buffer and flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_data_q   <= '0;
         o_keep_q   <= '0;
         o_last_q   <= 1'b0;
         o_valid_q  <= 1'b0;
         s_data_q   <= '0;
         s_keep_q   <= '0;
         s_last_q   <= 1'b0;
         s_valid_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         o_data_q   <= o_data_d;
         o_keep_q   <= o_keep_d;
         o_last_q   <= o_last_d;
         o_valid_q  <= o_valid_d;
         s_data_q   <= s_data_d;
         s_keep_q   <= s_keep_d;
         s_last_q   <= s_last_d;
         s_valid_q  <= s_valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign m_axis_tdata  = o_data_q;
   assign m_axis_tkeep  = o_keep_q;
   assign m_axis_tlast  = o_last_q;
   assign m_axis_tvalid = o_valid_q;
   assign overflow      = overflow_q;

`ifdef RX_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   // Delivered-beat and delivered-frame counts; both wrap naturally.
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (pop) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
         if (o_last_q) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_rx_axis_adapter.sv
// Testbench for rx_axis_adapter: a directed vector table, a queue-based reference
// model under random stimulus, and hand-written overflow and reset sequences.
module tb_rx_axis_adapter;

   localparam int DW    = 112;
   localparam int MW    = 4;
   localparam int BYTES = DW / 8;
   localparam int CW    = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW+MW-1:0]  rx_int_data;
   logic              rx_int_valid;
   logic              rx_int_ready;
   logic [DW-1:0]     m_axis_tdata;
   logic [BYTES-1:0]  m_axis_tkeep;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              overflow;
`ifdef RX_STATS_EN
   logic [CW-1:0]     frame_cnt;
   logic [CW-1:0]     beat_cnt;
`endif

   rx_axis_adapter #(.DWIDTH(DW), .MTY_W(MW), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_int_data   (rx_int_data),
      .rx_int_valid  (rx_int_valid),
      .rx_int_ready  (rx_int_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .overflow      (overflow)
`ifdef RX_STATS_EN
      ,
      .frame_cnt     (frame_cnt),
      .beat_cnt      (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0]    data;
      logic [BYTES-1:0] keep;
      logic             last;
   } beat_t;

   beat_t mq[$];
   bit    m_ovf;
   int    m_beats;
   int    m_frames;

   function automatic int eff_bytes(input int mty);
      if (mty > BYTES) return BYTES - 1;
      return mty;
   endfunction

   function automatic logic [BYTES-1:0] exp_keep(input int mty);
      int n;
      logic [BYTES:0] ones;
      n = eff_bytes(mty);
      ones = (BYTES+1)'((1 << n) - 1);
      return BYTES'(ones << (BYTES - n));
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf    = 0;
      m_beats  = 0;
      m_frames = 0;
   endtask

   // One clock: drive inputs, advance the model across the edge, compare after it.
   task automatic cycle(input bit v, input int mty, input logic [DW-1:0] d, input bit tr);
      int    occ;
      beat_t b;
      rx_int_valid  = v;
      rx_int_data   = {d, MW'(mty)};
      m_axis_tready = tr;
      occ = mq.size();
      if (v && mty != 0 && occ >= 2) m_ovf = 1;
      if (occ > 0 && tr) begin
         m_beats++;
         if (mq[0].last) m_frames++;
         void'(mq.pop_front());
      end
      if (v && mty != 0 && occ < 2) begin
         b.data = d;
         b.keep = exp_keep(mty);
         b.last = (eff_bytes(mty) != BYTES);
         mq.push_back(b);
      end
      @(negedge clk);
      chk("tvalid", 128'(m_axis_tvalid), 128'(mq.size() != 0));
      chk("ready", 128'(rx_int_ready), 128'(mq.size() < 2));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      if (mq.size() != 0) begin
         chk("tdata", 128'(m_axis_tdata), 128'(mq[0].data));
         chk("tkeep", 128'(m_axis_tkeep), 128'(mq[0].keep));
         chk("tlast", 128'(m_axis_tlast), 128'(mq[0].last));
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      rx_int_valid  = 1'b0;
      rx_int_data   = '0;
      m_axis_tready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 50;
      while (mq.size() != 0 && budget > 0) begin
         cycle(0, 0, '0, 1);
         budget--;
      end
      chk(name, 128'(mq.size()), 128'(0));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit               v;
      int               mty;
      bit               tr;
      bit               e_tvalid;
      bit               e_ready;
      bit               e_last;
      logic [BYTES-1:0] e_keep;
   } vec_t;

   vec_t vt[14];

   initial begin
      vt[0]  = '{1, 14, 1, 1, 1, 0, 14'h3FFF};
      vt[1]  = '{1, 14, 1, 1, 1, 0, 14'h3FFF};
      vt[2]  = '{1,  5, 1, 1, 1, 1, 14'h3E00};
      vt[3]  = '{0,  0, 1, 0, 1, 0, 14'h0000};
      vt[4]  = '{1, 14, 0, 1, 1, 0, 14'h3FFF};
      vt[5]  = '{1,  3, 0, 1, 0, 0, 14'h3FFF};
      vt[6]  = '{0,  0, 1, 1, 1, 1, 14'h3800};
      vt[7]  = '{0,  0, 1, 0, 1, 0, 14'h0000};
      vt[8]  = '{1,  0, 1, 0, 1, 0, 14'h0000};
      vt[9]  = '{1,  0, 1, 0, 1, 0, 14'h0000};
      vt[10] = '{1,  0, 1, 0, 1, 0, 14'h0000};
      vt[11] = '{1,  0, 1, 0, 1, 0, 14'h0000};
      vt[12] = '{1, 15, 0, 1, 1, 1, 14'h3FFE};
      vt[13] = '{0,  0, 1, 0, 1, 0, 14'h0000};
   end

   logic [DW-1:0] dA, dB, dC;

   initial begin
      rst_n         = 1'b0;
      rx_int_valid  = 1'b0;
      rx_int_data   = '0;
      m_axis_tready = 1'b0;
      model_reset();
      @(negedge clk);

      // reset state
      do_reset();
      chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      chk("rst_ready", 128'(rx_int_ready), 128'(1));
      chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
      chk("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
`ifdef RX_STATS_EN
      chk("rst_beat_cnt", 128'(beat_cnt), 128'(0));
      chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
`endif

      // directed table: streaming, backpressure, idle filter, mty clamp
      for (int i = 0; i < 14; i++) begin
         rx_int_valid  = vt[i].v;
         rx_int_data   = {{BYTES{8'(i + 1)}}, MW'(vt[i].mty)};
         m_axis_tready = vt[i].tr;
         @(negedge clk);
         chk($sformatf("vec%0d_tvalid", i), 128'(m_axis_tvalid), 128'(vt[i].e_tvalid));
         chk($sformatf("vec%0d_ready", i), 128'(rx_int_ready), 128'(vt[i].e_ready));
         chk($sformatf("vec%0d_overflow", i), 128'(overflow), 128'(0));
         if (vt[i].e_tvalid) begin
            chk($sformatf("vec%0d_tkeep", i), 128'(m_axis_tkeep), 128'(vt[i].e_keep));
            chk($sformatf("vec%0d_tlast", i), 128'(m_axis_tlast), 128'(vt[i].e_last));
         end
      end
`ifdef RX_STATS_EN
      chk("vec_beat_cnt", 128'(beat_cnt), 128'(6));
      chk("vec_frame_cnt", 128'(frame_cnt), 128'(3));
`endif

      // random stimulus against the queue model, source honours ready
      do_reset();
      for (int n = 0; n < 600; n++) begin
         int  mty;
         bit  v;
         mty = ($urandom_range(0, 3) == 0) ? 14 : int'($urandom_range(0, 15));
         v   = ($urandom_range(0, 3) != 0);
         if (mq.size() >= 2 && mty != 0) v = 0;
         cycle(v, mty, rand_data(), $urandom_range(0, 9) < 7);
      end
      drain("rand_drain");

      // overflow: fill both entries, idle beat must not flag, real beat must
      do_reset();
      dA = rand_data();
      dB = rand_data();
      dC = rand_data();
      cycle(1, 14, dA, 0);
      cycle(1, 9, dB, 0);
      chk("ovf_full_ready", 128'(rx_int_ready), 128'(0));
      cycle(1, 0, dC, 0);
      chk("ovf_idle_noset", 128'(overflow), 128'(0));
      cycle(1, 14, dC, 0);
      chk("ovf_set", 128'(overflow), 128'(1));
      cycle(0, 0, '0, 1);
      chk("ovf_first_out", 128'(m_axis_tdata), 128'(dB));
      cycle(0, 0, '0, 1);
      chk("ovf_dropped_absent", 128'(m_axis_tvalid), 128'(0));
      repeat (3) cycle(0, 0, '0, 1);
      chk("ovf_sticky", 128'(overflow), 128'(1));

      // reset mid-frame drops buffered beats and clears the flag
      cycle(1, 14, dA, 0);
      cycle(1, 14, dB, 0);
      do_reset();
      chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("midrst_ready", 128'(rx_int_ready), 128'(1));
      chk("midrst_overflow", 128'(overflow), 128'(0));

`ifdef RX_STATS_EN
      // 10 two-beat frames under random tready; counts wrap at 2**CW
      for (int f = 0; f < 10; f++) begin
         for (int b = 0; b < 2; b++) begin
            int budget;
            budget = 50;
            while (mq.size() >= 2 && budget > 0) begin
               cycle(0, 0, '0, $urandom_range(0, 1) == 1);
               budget--;
            end
            cycle(1, (b == 0) ? 14 : 7, rand_data(), $urandom_range(0, 1) == 1);
         end
      end
      drain("stats_drain");
      repeat (4) cycle(1, 0, '0, 1);
      chk("stats_beat_cnt", 128'(beat_cnt), 128'(20 % (1 << CW)));
      chk("stats_frame_cnt", 128'(frame_cnt), 128'(10 % (1 << CW)));
      chk("stats_model_beats", 128'(beat_cnt), 128'(m_beats % (1 << CW)));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
